// File: rtl/param_update_ctrl.sv
// -----------------------------------------------------------------------------
// param_update_ctrl
//
// Front-end for the two parameter-update lines coming from the UI encoder and
// buttons (bit0 = increment, bit1 = decrement). Each line goes through a 2-FF
// synchroniser and a per-bit debouncer. A debounced rising edge sets a sticky
// edge-capture bit and moves a saturating signed net step count by one. The
// controller raises a maskable level interrupt to the Nios. Software reaches
// it through an Avalon-MM slave.
//
// Ports:
//   clk, reset_n   system clock; asynchronous active-low reset
//   address        Avalon word address
//                    0 DATA     (RO)  debounced state [1:0]
//                    1 IRQMASK  (RW)  [1:0]
//                    2 EDGECAP  (R/W1C) [1:0]
//                    3 STEP     (RO, clear-on-read) sign-extended count
//   chipselect     Avalon select
//   write_n        Avalon write strobe, active-low
//   read           Avalon read strobe; used only for the STEP clear side effect
//   writedata      Avalon write data
//   readdata       registered read data, one cycle after address
//   in_port        raw asynchronous update lines
//   irq            level interrupt, active-high
// -----------------------------------------------------------------------------
module param_update_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int STEP_W          = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic        read,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [1:0]  in_port,
    output logic        irq
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_MAX = {1'b0, {(STEP_W-1){1'b1}}};
    localparam logic [STEP_W-1:0] STEP_MIN = {1'b1, {(STEP_W-1){1'b0}}};

    logic [1:0]        sync1_r;
    logic [1:0]        sync2_r;
    logic [1:0]        deb_r;
    logic [CNT_W-1:0]  cnt_r [2];
    logic [1:0]        irqmask_r;
    logic [1:0]        edgecap_r;
    logic [STEP_W-1:0] step_r;

    logic [CNT_W-1:0]  cnt_next_s [2];
    logic [1:0]        flip_s;
    logic [1:0]        rise_s;
    logic              wr_s;
    logic              wr_mask_s;
    logic              wr_ecap_s;
    logic              step_clr_s;
    logic [1:0]        irqmask_next_s;
    logic [1:0]        edgecap_next_s;
    logic [STEP_W-1:0] step_next_s;
    logic [31:0]       rdata_next_s;
    logic              unused_s;

    // Upper write-data bits have no storage behind them.
    assign unused_s = &{1'b0, writedata[31:2]};

    // Debounce: count while the synchronised level differs, flip on the last count.
    always_comb begin
        flip_s = 2'b00;
        for (int i = 0; i < 2; i++) begin
            cnt_next_s[i] = {CNT_W{1'b0}};
            if (sync2_r[i] != deb_r[i]) begin
                if (cnt_r[i] == CNT_LAST) begin
                    flip_s[i]     = 1'b1;
                    cnt_next_s[i] = {CNT_W{1'b0}};
                end else begin
                    cnt_next_s[i] = cnt_r[i] + CNT_W'(1);
                end
            end else begin
                cnt_next_s[i] = {CNT_W{1'b0}};
            end
        end
        // A flip towards 1 is a rising edge; falling flips are not reported.
        rise_s = flip_s & sync2_r;
    end

    // Host access decode and next values of the host-visible registers.
    always_comb begin
        wr_s       = chipselect & ~write_n;
        wr_mask_s  = wr_s & (address == 2'd1);
        wr_ecap_s  = wr_s & (address == 2'd2);
        step_clr_s = chipselect & read & (address == 2'd3);

        if (wr_mask_s) begin
            irqmask_next_s = writedata[1:0];
        end else begin
            irqmask_next_s = irqmask_r;
        end

        // Set has priority over a coincident write-1-to-clear.
        if (wr_ecap_s) begin
            edgecap_next_s = (edgecap_r & ~writedata[1:0]) | rise_s;
        end else begin
            edgecap_next_s = edgecap_r | rise_s;
        end

        // Clear-on-read reloads with this cycle's delta so no event is dropped.
        step_next_s = step_r;
        if (step_clr_s) begin
            case (rise_s)
                2'b01:   step_next_s = STEP_W'(1);
                2'b10:   step_next_s = {STEP_W{1'b1}};
                default: step_next_s = {STEP_W{1'b0}};
            endcase
        end else begin
            case (rise_s)
                2'b01:   step_next_s = (step_r == STEP_MAX) ? step_r : step_r + STEP_W'(1);
                2'b10:   step_next_s = (step_r == STEP_MIN) ? step_r : step_r - STEP_W'(1);
                default: step_next_s = step_r;
            endcase
        end
    end

    // Read mux; captured every cycle regardless of chipselect.
    always_comb begin
        case (address)
            2'd0:    rdata_next_s = {30'd0, deb_r};
            2'd1:    rdata_next_s = {30'd0, irqmask_r};
            2'd2:    rdata_next_s = {30'd0, edgecap_r};
            2'd3:    rdata_next_s = 32'($signed(step_r));
            default: rdata_next_s = 32'd0;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r   <= 2'b00;
            sync2_r   <= 2'b00;
            deb_r     <= 2'b00;
            cnt_r[0]  <= {CNT_W{1'b0}};
            cnt_r[1]  <= {CNT_W{1'b0}};
            irqmask_r <= 2'b00;
            edgecap_r <= 2'b00;
            step_r    <= {STEP_W{1'b0}};
            readdata  <= 32'd0;
            irq       <= 1'b0;
        end else begin
            sync1_r   <= in_port;
            sync2_r   <= sync1_r;
            deb_r     <= deb_r ^ flip_s;
            cnt_r[0]  <= cnt_next_s[0];
            cnt_r[1]  <= cnt_next_s[1];
            irqmask_r <= irqmask_next_s;
            edgecap_r <= edgecap_next_s;
            step_r    <= step_next_s;
            readdata  <= rdata_next_s;
            irq       <= |(edgecap_next_s & irqmask_next_s);
        end
    end

endmodule

// File: tb/tb_param_update_ctrl.sv
// -----------------------------------------------------------------------------
// Directed bench for param_update_ctrl with DEBOUNCE_CYCLES = 8. A second
// instance with STEP_W = 4 shares every input, so its count saturates at +7.
// -----------------------------------------------------------------------------
module tb_param_update_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] readdata4;
    logic [1:0]  in_port;
    logic        irq;
    logic        irq4;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] d;
    logic [31:0] d4;

    always #5 clk = ~clk;

    param_update_ctrl #(.DEBOUNCE_CYCLES(8), .STEP_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .read(read), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    param_update_ctrl #(.DEBOUNCE_CYCLES(8), .STEP_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .read(read), .writedata(writedata), .readdata(readdata4),
        .in_port(in_port), .irq(irq4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] r, output logic [31:0] r4);
        address    = a;
        chipselect = 1'b1;
        read       = 1'b1;
        tick();
        r          = readdata;
        r4         = readdata4;
        chipselect = 1'b0;
        read       = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] data);
        address    = a;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic press(input int b);
        in_port[b] = 1'b1;
        repeat (12) tick();
        in_port[b] = 1'b0;
        repeat (12) tick();
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        read       = 1'b0;
        writedata  = 32'd0;
        in_port    = 2'b00;
        repeat (3) tick();
        reset_n = 1'b1;

        // Reset state
        chk("reset_irq", {31'd0, irq}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d, d4);
            chk("reset_read", d, 32'd0);
        end

        // Single inc line held high, interrupt unmasked on bit0
        wr(2'd1, 32'h1);
        rd(2'd1, d, d4);
        chk("irqmask_rw", d, 32'h1);
        in_port = 2'b01;
        repeat (9) tick();
        chk("irq_before_latency", {31'd0, irq}, 32'd0);
        tick();
        chk("irq_at_latency", {31'd0, irq}, 32'd1);
        chk("irq4_at_latency", {31'd0, irq4}, 32'd1);
        repeat (10) tick();
        rd(2'd0, d, d4);
        chk("data_inc_high", d, 32'h1);
        rd(2'd2, d, d4);
        chk("edgecap_inc", d, 32'h1);
        rd(2'd3, d, d4);
        chk("step_plus1", d, 32'h1);
        wr(2'd2, 32'h1);
        chk("irq_after_w1c", {31'd0, irq}, 32'd0);
        rd(2'd2, d, d4);
        chk("edgecap_cleared", d, 32'h0);
        in_port = 2'b00;
        repeat (12) tick();
        rd(2'd0, d, d4);
        chk("data_released", d, 32'h0);
        rd(2'd2, d, d4);
        chk("falling_ignored", d, 32'h0);

        // Short glitches never reach the debounced state
        for (int k = 0; k < 10; k++) begin
            in_port = 2'b01;
            repeat (5) tick();
            in_port = 2'b00;
            repeat (5) tick();
        end
        repeat (12) tick();
        rd(2'd0, d, d4);
        chk("glitch_data", d, 32'h0);
        rd(2'd2, d, d4);
        chk("glitch_edgecap", d, 32'h0);
        rd(2'd3, d, d4);
        chk("glitch_step", d, 32'h0);

        // Three inc and five dec presses give -2; the read clears it
        for (int k = 0; k < 3; k++) press(0);
        for (int k = 0; k < 5; k++) press(1);
        rd(2'd3, d, d4);
        chk("step_minus2", d, 32'hFFFF_FFFE);
        chk("step4_minus2", d4, 32'hFFFF_FFFE);
        rd(2'd3, d, d4);
        chk("step_clear_on_read", d, 32'h0);
        rd(2'd2, d, d4);
        chk("edgecap_both", d, 32'h3);
        chk("irq_masked_bit0", {31'd0, irq}, 32'd1);
        wr(2'd2, 32'h3);
        chk("irq_after_clear_all", {31'd0, irq}, 32'd0);

        // Both lines rising together: both captured, no net step
        in_port = 2'b11;
        repeat (12) tick();
        rd(2'd2, d, d4);
        chk("edgecap_simul", d, 32'h3);
        rd(2'd3, d, d4);
        chk("step_simul", d, 32'h0);
        in_port = 2'b00;
        repeat (12) tick();
        wr(2'd2, 32'h3);

        // STEP read in the same cycle as an inc rise
        press(1);
        in_port = 2'b01;
        repeat (9) tick();
        rd(2'd3, d, d4);
        chk("step_read_pre_clear", d, 32'hFFFF_FFFF);
        rd(2'd3, d, d4);
        chk("step_coincident_delta", d, 32'h1);
        in_port = 2'b00;
        repeat (12) tick();

        // Partial W1C, then W1C coincident with rise[1]
        wr(2'd2, 32'h2);
        rd(2'd2, d, d4);
        chk("edgecap_partial_w1c", d, 32'h1);
        in_port = 2'b10;
        repeat (9) tick();
        wr(2'd2, 32'h3);
        rd(2'd2, d, d4);
        chk("edgecap_set_wins", d, 32'h2);
        chk("irq_bit1_masked", {31'd0, irq}, 32'd0);
        wr(2'd1, 32'h3);
        chk("irq_bit1_unmasked", {31'd0, irq}, 32'd1);
        in_port = 2'b00;
        repeat (12) tick();

        // Saturation: 9 inc presses -> 9 on 16-bit, +7 on 4-bit
        rd(2'd3, d, d4);
        chk("step_minus1", d, 32'hFFFF_FFFF);
        chk("step4_minus1", d4, 32'hFFFF_FFFF);
        for (int k = 0; k < 9; k++) press(0);
        rd(2'd3, d, d4);
        chk("step_nine", d, 32'd9);
        chk("step4_saturated", d4, 32'd7);

        // Reset mid-debounce with the inc line held high through reset
        in_port = 2'b01;
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        chk("irq_async_reset", {31'd0, irq}, 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (9) tick();
        rd(2'd2, d, d4);
        chk("edgecap_before_rerise", d, 32'h0);
        rd(2'd2, d, d4);
        chk("edgecap_after_rerise", d, 32'h1);
        rd(2'd1, d, d4);
        chk("irqmask_reset", d, 32'h0);
        rd(2'd3, d, d4);
        chk("step_after_reset", d, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
